// File: rtl/vape_exec_pkg.sv
// Shared state encoding, cause-bit layout and default re-arm vector for the
// multi-region EXEC monitor.
`default_nettype none

package vape_exec_pkg;

  localparam logic ST_ABORT = 1'b0;
  localparam logic ST_EXEC  = 1'b1;

  typedef enum logic {
    S_ABORT = ST_ABORT,
    S_EXEC  = ST_EXEC
  } state_e;

  localparam int CAUSE_CPU = 0;
  localparam int CAUSE_DMA = 1;
  localparam int CAUSE_CFG = 2;
  localparam int CAUSE_W   = 3;

  localparam logic [15:0] DEF_RESET_HANDLER = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/vape_exec_region.sv
// One protected region: EXEC/ABORT FSM, bounds shadow, sticky cause and a
// saturating abort counter.
`default_nettype none

module vape_exec_region
  import vape_exec_pkg::*;
#(
  parameter int                ADDR_W        = 16,
  parameter int                CNT_W         = 8,
  parameter logic [ADDR_W-1:0] RESET_HANDLER = '0
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic [ADDR_W-1:0]  i_data_addr,
  input  logic               i_data_en,
  input  logic [ADDR_W-1:0]  i_dma_addr,
  input  logic               i_dma_en,
  input  logic               i_en,
  input  logic [ADDR_W-1:0]  i_min,
  input  logic [ADDR_W-1:0]  i_max,
  output logic               o_exec,
  output logic               o_exec_nxt,
  output logic [CAUSE_W-1:0] o_cause,
  output logic [CNT_W-1:0]   o_cnt
);

  state_e              r_state, w_state_nxt;
  logic [CAUSE_W-1:0]  r_cause, w_cause_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]   r_sh_min, r_sh_max;
  logic                r_sh_vld;

  logic                w_nonempty, w_cpu_hit, w_dma_hit, w_cfg_hit, w_any_hit;
  logic [CAUSE_W-1:0]  w_hits;

  assign w_nonempty = (i_min <= i_max);
  assign w_cpu_hit  = i_data_en && w_nonempty && (i_data_addr >= i_min) && (i_data_addr <= i_max);
  assign w_dma_hit  = i_dma_en  && w_nonempty && (i_dma_addr  >= i_min) && (i_dma_addr  <= i_max);
  // The shadow is meaningless until it has captured the bounds once after reset.
  assign w_cfg_hit  = r_sh_vld && ((i_min != r_sh_min) || (i_max != r_sh_max));
  assign w_any_hit  = w_cpu_hit || w_dma_hit || w_cfg_hit;

  always_comb begin
    w_hits            = '0;
    w_hits[CAUSE_CPU] = w_cpu_hit;
    w_hits[CAUSE_DMA] = w_dma_hit;
    w_hits[CAUSE_CFG] = w_cfg_hit;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_EXEC: begin
        if (w_any_hit || !i_en) begin
          w_state_nxt            = S_ABORT;
          w_cause_nxt            = w_hits;
          w_cause_nxt[CAUSE_CFG] = w_cfg_hit || !i_en;
          w_cnt_nxt              = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
        end
      end
      S_ABORT: begin
        if ((i_pc == RESET_HANDLER) && i_en && !w_any_hit) begin
          w_state_nxt = S_EXEC;
          w_cause_nxt = '0;
        end else begin
          w_cause_nxt = r_cause | w_hits;
        end
      end
      default: w_state_nxt = S_ABORT;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_ABORT;
      r_cause  <= '0;
      r_cnt    <= '0;
      r_sh_min <= '0;
      r_sh_max <= '0;
      r_sh_vld <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cause  <= w_cause_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sh_min <= i_min;
      r_sh_max <= i_max;
      r_sh_vld <= 1'b1;
    end
  end

  assign o_exec     = (r_state == S_EXEC);
  assign o_exec_nxt = (w_state_nxt == S_EXEC);
  assign o_cause    = r_cause;
  assign o_cnt      = r_cnt;

endmodule

`default_nettype wire

// File: rtl/vape_exec_monitor_multi.sv
// Multi-region EXEC flag monitor: per-region trackers plus a registered
// AND of the enabled regions' flags.
`default_nettype none

module vape_exec_monitor_multi
  import vape_exec_pkg::*;
#(
  parameter int                NUM_REGIONS   = 4,
  parameter int                ADDR_W        = 16,
  parameter int                CNT_W         = 8,
  parameter logic [ADDR_W-1:0] RESET_HANDLER = ADDR_W'(DEF_RESET_HANDLER)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [ADDR_W-1:0]             pc,
  input  logic [ADDR_W-1:0]             data_addr,
  input  logic                          data_en,
  input  logic [ADDR_W-1:0]             dma_addr,
  input  logic                          dma_en,
  input  logic [NUM_REGIONS-1:0]        region_en,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_min,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_max,
  output logic [NUM_REGIONS-1:0]        exec,
  output logic                          exec_all,
  output logic [3*NUM_REGIONS-1:0]      abort_cause,
  output logic [CNT_W*NUM_REGIONS-1:0]  abort_cnt
);

  logic [NUM_REGIONS-1:0] w_exec_nxt;
  logic                   r_exec_all;

  for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
    vape_exec_region #(
      .ADDR_W        (ADDR_W),
      .CNT_W         (CNT_W),
      .RESET_HANDLER (RESET_HANDLER)
    ) u_region (
      .clk         (clk),
      .i_rst_n     (reset_n),
      .i_pc        (pc),
      .i_data_addr (data_addr),
      .i_data_en   (data_en),
      .i_dma_addr  (dma_addr),
      .i_dma_en    (dma_en),
      .i_en        (region_en[gi]),
      .i_min       (region_min[gi*ADDR_W +: ADDR_W]),
      .i_max       (region_max[gi*ADDR_W +: ADDR_W]),
      .o_exec      (exec[gi]),
      .o_exec_nxt  (w_exec_nxt[gi]),
      .o_cause     (abort_cause[gi*3 +: 3]),
      .o_cnt       (abort_cnt[gi*CNT_W +: CNT_W])
    );
  end

  // Built from next-state flags so it lands in the same cycle as exec.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_exec_all <= 1'b0;
    end else begin
      r_exec_all <= (|region_en) && (&(w_exec_nxt | ~region_en));
    end
  end

  assign exec_all = r_exec_all;

endmodule

`default_nettype wire
